// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state,
// write-back control bundle and the bubble constant.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0};

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the control bundle;
// the data fields keep their previous contents.
module mem_wb_reg
    import mem_pkg::*;
#(
    parameter int DW = WORD_W,
    parameter int RW = REG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble_i,
    input  wb_ctrl_t      ctrl_i,
    input  logic [DW-1:0] alu_res_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic [RW-1:0] wreg_i,
    output wb_ctrl_t      ctrl_o,
    output logic [DW-1:0] alu_res_o,
    output logic [DW-1:0] mem_data_o,
    output logic [RW-1:0] wreg_o
);

    wb_ctrl_t      ctrl_q;
    logic [DW-1:0] alu_res_q;
    logic [DW-1:0] mem_data_q;
    logic [RW-1:0] wreg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= WB_BUBBLE;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            wreg_q     <= '0;
        end else if (bubble_i) begin
            ctrl_q     <= WB_BUBBLE;
        end else begin
            ctrl_q     <= ctrl_i;
            alu_res_q  <= alu_res_i;
            mem_data_q <= mem_data_i;
            wreg_q     <= wreg_i;
        end
    end

    assign ctrl_o     = ctrl_q;
    assign alu_res_o  = alu_res_q;
    assign mem_data_o = mem_data_q;
    assign wreg_o     = wreg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access FSM, upstream stall and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN turns misaligned accesses into flagged no-ops.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DW = WORD_W,
    parameter int RW = REG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MEM_MemtoReg,
    input  logic          MEM_RegWrite,
    input  logic          MEM_MemRead,
    input  logic          MEM_MemWrite,
    input  logic [DW-1:0] MEM_ALU_res,
    input  logic [DW-1:0] MEM_rdata2,
    input  logic [RW-1:0] MEM_wreg,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          mem_stall,
    output logic          WB_MemtoReg,
    output logic          WB_RegWrite,
    output logic [DW-1:0] WB_mem_data,
    output logic [DW-1:0] WB_ALU_res,
    output logic [RW-1:0] WB_wreg
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic          misalign
`endif
);

    localparam logic [DW-1:0] ALIGN_MASK = ~DW'(3);

    mem_state_t    state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          acc;
    logic          mis;
    logic          stall;
    logic          bubble;
    wb_ctrl_t      wb_ctrl;
    wb_ctrl_t      wb_ctrl_out;

    assign acc = MEM_MemRead | MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign mis = acc & (|MEM_ALU_res[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        we_d             = we_q;
        rdata_d          = rdata_q;
        stall            = 1'b0;
        dmem_req         = 1'b0;
        bubble           = 1'b0;
        wb_ctrl.memtoreg = MEM_MemtoReg;
        wb_ctrl.regwrite = MEM_RegWrite;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (acc && !mis) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = BUSY;
                    addr_d  = MEM_ALU_res & ALIGN_MASK;
                    wdata_d = MEM_rdata2;
                    // MemWrite wins when both MemRead and MemWrite are set.
                    we_d    = MEM_MemWrite;
                end
`ifdef MEM_ALIGN_CHECK_EN
                else if (mis) begin
                    wb_ctrl.regwrite = 1'b0;
                    misalign_d       = 1'b1;
                end
`endif
            end
            BUSY: begin
                dmem_req = 1'b1;
                stall    = 1'b1;
                bubble   = 1'b1;
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    state_d = DONE;
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b0;
                end
            end
            DONE: begin
                // EX/MEM still holds this instruction; retire it and go idle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign misalign = misalign_q;
`endif

    mem_wb_reg #(
        .DW(DW),
        .RW(RW)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble_i   (bubble),
        .ctrl_i     (wb_ctrl),
        .alu_res_i  (MEM_ALU_res),
        .mem_data_i (rdata_q),
        .wreg_i     (MEM_wreg),
        .ctrl_o     (wb_ctrl_out),
        .alu_res_o  (WB_ALU_res),
        .mem_data_o (WB_mem_data),
        .wreg_o     (WB_wreg)
    );

    assign mem_stall   = stall & ~rst;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_we     = we_q;
    assign WB_MemtoReg = wb_ctrl_out.memtoreg;
    assign WB_RegWrite = wb_ctrl_out.regwrite;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected
// write-backs; a negedge monitor pops and compares every WB_RegWrite pulse.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_MemtoReg, MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [31:0] MEM_ALU_res, MEM_rdata2;
    logic [4:0]  MEM_wreg;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall;
    logic        WB_MemtoReg, WB_RegWrite;
    logic [31:0] WB_mem_data, WB_ALU_res;
    logic [4:0]  WB_wreg;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_access_stage dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_MemtoReg (MEM_MemtoReg),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_ALU_res  (MEM_ALU_res),
        .MEM_rdata2   (MEM_rdata2),
        .MEM_wreg     (MEM_wreg),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .mem_stall    (mem_stall),
        .WB_MemtoReg  (WB_MemtoReg),
        .WB_RegWrite  (WB_RegWrite),
        .WB_mem_data  (WB_mem_data),
        .WB_ALU_res   (WB_ALU_res),
        .WB_wreg      (WB_wreg)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign     (misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        m2r;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wb_events = 0;
    int   wb_cyc_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write-back pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && WB_RegWrite === 1'b1) begin
            wb_events++;
            wb_cyc_log.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wb_unexpected: got write wreg=%0d alu=0x%08h, required no write",
                         WB_wreg, WB_ALU_res);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_alu_res", WB_ALU_res, mon_e.alu);
                check("wb_wreg", 32'(WB_wreg), 32'(mon_e.wreg));
                check("wb_memtoreg", 32'(WB_MemtoReg), 32'(mon_e.m2r));
                if (mon_e.chk_data) check("wb_mem_data", WB_mem_data, mon_e.data);
                $display("WB  cyc=%0d wreg=%0d alu=0x%08h mem_data=0x%08h m2r=%0d",
                         cyc, WB_wreg, WB_ALU_res, WB_mem_data, WB_MemtoReg);
            end
        end
    end

    task automatic set_nop();
        MEM_MemtoReg = 1'b0;
        MEM_RegWrite = 1'b0;
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        MEM_ALU_res  = '0;
        MEM_rdata2   = '0;
        MEM_wreg     = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction (called just after a rising edge), play the
    // memory side, and return just after the edge that retires it.
    task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] widx,
                         input int ack_wait, input logic [31:0] rdata, input bit expect_wb,
                         output int stall_cyc, output int req_cyc, output int stable_err,
                         output logic [31:0] first_addr, output logic [31:0] first_wdata,
                         output logic first_we);
        exp_t e;
        bit   done;
        MEM_MemRead  = rd;
        MEM_MemWrite = wr;
        MEM_MemtoReg = m2r;
        MEM_RegWrite = rw;
        MEM_ALU_res  = alu;
        MEM_rdata2   = wd;
        MEM_wreg     = widx;
        if (expect_wb) begin
            e.alu      = alu;
            e.wreg     = widx;
            e.m2r      = m2r;
            e.chk_data = rd & ~wr;
            e.data     = rdata;
            sb_q.push_back(e);
        end
        stall_cyc   = 0;
        req_cyc     = 0;
        stable_err  = 0;
        first_addr  = '0;
        first_wdata = '0;
        first_we    = 1'b0;
        done        = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (mem_stall) stall_cyc++;
            if (dmem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    first_addr  = dmem_addr;
                    first_wdata = dmem_wdata;
                    first_we    = dmem_we;
                end else if (dmem_addr !== first_addr || dmem_wdata !== first_wdata ||
                             dmem_we !== first_we) begin
                    stable_err++;
                end
            end
            dmem_ack   = dmem_req && (req_cyc == ack_wait + 1);
            dmem_rdata = rdata;
            if (!mem_stall) done = 1'b1;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout: got stall still high after 64 cycles, required release");
        end
        $display("ISS addr=0x%08h rd=%0d wr=%0d wreg=%0d stall=%0d req=%0d",
                 alu, rd, wr, widx, stall_cyc, req_cyc);
        set_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          st, rq, se, ev0, n0;
        logic [31:0] fa, fw;
        logic        fwe;

        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        set_nop();
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_wb_memtoreg", 32'(WB_MemtoReg), 32'd0);
        check("rst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("rst_wb_mem_data", WB_mem_data, 32'd0);
        check("rst_wb_alu_res", WB_ALU_res, 32'd0);
        check("rst_wb_wreg", 32'(WB_wreg), 32'd0);
        check("rst_state_idle", 32'(dut.state_q), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("rst_misalign", 32'(misalign), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU op: one-cycle pass-through, no stall
        issue(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd7, 0, 32'h0, 1, st, rq, se, fa, fw, fwe);
        check("alu_stall_cycles", 32'(st), 32'd0);
        check("alu_req_cycles", 32'(rq), 32'd0);
        idle(2);

        // Load, ack on first BUSY cycle
        issue(1, 0, 1, 1, 32'h0000_0040, 32'h0, 5'd5, 0, 32'hDEAD_BEEF, 1, st, rq, se, fa, fw, fwe);
        check("ld_stall_cycles", 32'(st), 32'd2);
        check("ld_req_cycles", 32'(rq), 32'd1);
        check("ld_addr", fa, 32'h0000_0040);
        check("ld_we", 32'(fwe), 32'd0);
        idle(2);

        // Store, ack after 4 extra wait cycles
        ev0 = wb_events;
        issue(0, 1, 0, 0, 32'h0000_0080, 32'hCAFE_F00D, 5'd0, 4, 32'h0, 0, st, rq, se, fa, fw, fwe);
        check("st_stall_cycles", 32'(st), 32'd6);
        check("st_req_cycles", 32'(rq), 32'd5);
        check("st_stable_errors", 32'(se), 32'd0);
        check("st_we", 32'(fwe), 32'd1);
        check("st_addr", fa, 32'h0000_0080);
        check("st_wdata", fw, 32'hCAFE_F00D);
        idle(2);
        check("st_no_wb_write", 32'(wb_events), 32'(ev0));

        // Back-to-back load then ALU op
        n0 = wb_cyc_log.size();
        issue(1, 0, 1, 1, 32'h0000_0044, 32'h0, 5'd3, 1, 32'h1111_2222, 1, st, rq, se, fa, fw, fwe);
        check("b2b_ld_stall_cycles", 32'(st), 32'd3);
        issue(0, 0, 0, 1, 32'h0000_0055, 32'h0, 5'd9, 0, 32'h0, 1, st, rq, se, fa, fw, fwe);
        idle(2);
        check("b2b_wb_count", 32'(wb_cyc_log.size()), 32'(n0 + 2));
        if (wb_cyc_log.size() == n0 + 2)
            check("b2b_wb_gap", 32'(wb_cyc_log[n0 + 1] - wb_cyc_log[n0]), 32'd1);

        // Reset in the 2nd BUSY cycle, ack arriving one cycle later
        ev0 = wb_events;
        MEM_MemRead  = 1'b1;
        MEM_MemtoReg = 1'b1;
        MEM_RegWrite = 1'b1;
        MEM_ALU_res  = 32'h0000_0100;
        MEM_wreg     = 5'd4;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rbusy_req_before_rst", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        set_nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_0099;
        @(negedge clk);
        check("rbusy_dmem_req", 32'(dmem_req), 32'd0);
        check("rbusy_mem_stall", 32'(mem_stall), 32'd0);
        check("rbusy_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("rbusy_wb_memtoreg", 32'(WB_MemtoReg), 32'd0);
        check("rbusy_wb_alu_res", WB_ALU_res, 32'd0);
        check("rbusy_wb_mem_data", WB_mem_data, 32'd0);
        check("rbusy_wb_wreg", 32'(WB_wreg), 32'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        idle(3);
        check("rbusy_no_wb_write", 32'(wb_events), 32'(ev0));
        check("rbusy_dmem_req_later", 32'(dmem_req), 32'd0);

        // Misaligned load from 0x42
`ifdef MEM_ALIGN_CHECK_EN
        ev0 = wb_events;
        issue(1, 0, 1, 1, 32'h0000_0042, 32'h0, 5'd6, 0, 32'h0BAD_F00D, 0, st, rq, se, fa, fw, fwe);
        check("mis_req_cycles", 32'(rq), 32'd0);
        check("mis_stall_cycles", 32'(st), 32'd0);
        @(negedge clk);
        check("mis_flag_high", 32'(misalign), 32'd1);
        check("mis_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        @(negedge clk);
        check("mis_flag_one_cycle", 32'(misalign), 32'd0);
        idle(2);
        check("mis_no_wb_write", 32'(wb_events), 32'(ev0));
`else
        issue(1, 0, 1, 1, 32'h0000_0042, 32'h0, 5'd6, 0, 32'h0BAD_F00D, 1, st, rq, se, fa, fw, fwe);
        check("unal_addr", fa, 32'h0000_0040);
        check("unal_stall_cycles", 32'(st), 32'd2);
        idle(2);
`endif

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
